phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Single-clock phase controller for the CPU core. It generates the three instruction phases X (fetch), Y (decode), and Z (execute/writeback) as one-hot clock-enable strobes on the system clock, replacing divided or derived clocks. It adds run, halt and single-step control, stretches phases X and Z while memory is busy, and flags a fault on memory timeout. It sits between the debug/control port and the datapath, which advances only on these strobes.

## Interface
- `WAIT_LIMIT`, default 15: max consecutive busy cycles tolerated in X or Z; 0 disables the timeout.
- `COUNT_W`, default 16: width of the retired-instruction counter.

- `i_CLOCK`  in  1  system clock; all logic on posedge.
- `i_RESET_N`  in  1  asynchronous active-low reset.
- `i_RUN`  in  1  level; free-run enable.
- `i_STEP`  in  1  pulse; execute exactly one instruction; honoured only in HALTED.
- `i_MEM_BUSY`  in  1  memory not ready; stretches the current X or Z.
- `i_HALT`  in  1  decoded HALT instruction; sampled on the last cycle of Z.
- `o_CYCLEX`, `o_CYCLEY`, `o_CYCLEZ`  out  1 each  one-hot phase strobes.
- `o_ADVANCE`  out  1  current phase completes this cycle.
- `o_STATE`  out  3  encoded state.
- `o_RETIRE`  out  1  instruction completes this cycle.
- `o_INSTR_COUNT`  out  COUNT_W  retired-instruction count.
- `o_HALTED`  out  1  state is HALTED.
- `o_FAULT`  out  1  sticky memory-timeout fault.

## Operation
- State encoding: HALTED=0, X=1, Y=2, Z=3, FAULT=4. Codes 5–7 are illegal and go to FAULT.
- Phase strobes are Moore outputs: `o_CYCLEX` = (state==X), and likewise for Y and Z. All strobes are 0 in HALTED and FAULT.
- `o_ADVANCE` = (X or Z) && !i_MEM_BUSY, or state==Y.
- HALTED:
  - `i_RUN`=1 → X.
  - `i_STEP`=1 → X and set `step_mode`.
  - Both asserted → X with `step_mode` set.
- X:
  - If busy, stay in X and increment the wait counter.
  - Otherwise go to Y and clear the wait counter.
- Y: always → Z after one cycle.
- Z:
  - If busy, stretch the phase exactly as in X.
  - On completion, assert `o_RETIRE` and increment `o_INSTR_COUNT`; the count wraps modulo 2^COUNT_W.
  - Next state is HALTED if `i_HALT`, `step_mode`, or !`i_RUN`; otherwise X. `step_mode` clears on this transition.
- Timeout: if the wait counter reaches WAIT_LIMIT while still busy (WAIT_LIMIT≠0), go to FAULT. FAULT is left only by reset.
- Wait counter width is clog2(WAIT_LIMIT+1), minimum 1. It saturates and never wraps.

## Timing
- Reset values: state=HALTED; `o_HALTED`=1; all other outputs 0; counters 0; `step_mode`=0.
- Reset mid-instruction aborts it immediately; no retire is counted.
- Unstalled instruction takes 3 cycles, X→Y→Z. Each stall cycle adds 1.
- Throughput in free run: one retire every 3 cycles.
- Start latency: `i_RUN` sampled high in HALTED → `o_CYCLEX`=1 on the next cycle.
- Deasserting `i_RUN` mid-instruction has no effect until the end of Z. The instruction always completes.
- `i_HALT` together with `i_RUN`=1 at the end of Z: halt wins.
- `i_STEP` outside HALTED is ignored and not queued. A step held high for several cycles yields one instruction per HALTED entry.
- `i_MEM_BUSY` in Y or HALTED is ignored.
- Stall with WAIT_LIMIT=N: the X cycle at which the counter equals N with busy still high transitions to FAULT. That is, N+1 busy cycles in X cause FAULT; N busy cycles followed by ready proceed normally.
- `o_RETIRE` and `o_ADVANCE` are combinational from state and `i_MEM_BUSY`; the datapath samples them on the same edge.

## Structure
- Shared package `crforth_pkg`: state enum codes (HALTED, X, Y, Z, FAULT) and the 3-bit state width. These are shared with the debug port, which decodes `o_STATE`.
- One sub-module, `stall_timer`:
  - Inputs: clear, count-enable.
  - Parameter: WAIT_LIMIT.
  - Output: `expired`.
- The state machine, `step_mode`, and retire counter stay in the top level.

## Test plan
- Reset, then `i_RUN`=1 for 12 cycles with no busy → strobe pattern X,Y,Z ×4, `o_RETIRE` pulses on cycles 3, 6, 9, 12, `o_INSTR_COUNT`=4.
- HALTED, one-cycle `i_STEP`, then a second `i_STEP` during Y → exactly one instruction, return to HALTED, count=1, second step ignored.
- Running; busy for 3 cycles in X and 2 in Z (WAIT_LIMIT=15) → instruction spans 8 cycles, `o_ADVANCE` low during stalls, count +1.
- WAIT_LIMIT=4; busy held in X → FAULT after the 5th busy cycle, `o_FAULT`=1, strobes 0, `i_RUN` ignored until `i_RESET_N` pulse.
- `i_HALT`=1 on the last Z cycle with `i_RUN`=1 → HALTED next cycle; `i_RESET_N` low during Y → immediate HALTED, count unchanged.
- COUNT_W=4, run 17 instructions → `o_INSTR_COUNT`=1 (wrap).

Source files
------------

// File: rtl/crforth_pkg.sv
// Shared definitions for the phase sequencer and the debug port that decodes o_STATE.
package crforth_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HALTED = 3'd0,
    ST_X      = 3'd1,
    ST_Y      = 3'd2,
    ST_Z      = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // Bits needed to hold 0..limit, never fewer than one.
  function automatic int wait_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// Counts consecutive memory-busy cycles within one X or Z phase; flags when the
// tolerated stall budget is used up. Saturates rather than wrapping.
module stall_timer
  import crforth_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CNT_W = wait_cnt_w(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WAIT_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first, so no branch leaves cnt_d unassigned and infers a latch.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (WAIT_LIMIT == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      assign expired_o = (cnt_q == LIMIT_C);
    end
  endgenerate

endmodule

// File: rtl/phase_sequencer.sv
// Generates one-hot X/Y/Z phase strobes with run, halt and single-step control,
// memory-busy stretching of X and Z, a sticky timeout fault and a retire counter.
module phase_sequencer
  import crforth_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int COUNT_W    = 16
) (
  input  logic               i_CLOCK,
  input  logic               i_RESET_N,
  input  logic               i_RUN,
  input  logic               i_STEP,
  input  logic               i_MEM_BUSY,
  input  logic               i_HALT,
  output logic               o_CYCLEX,
  output logic               o_CYCLEY,
  output logic               o_CYCLEZ,
  output logic               o_ADVANCE,
  output logic [STATE_W-1:0] o_STATE,
  output logic               o_RETIRE,
  output logic [COUNT_W-1:0] o_INSTR_COUNT,
  output logic               o_HALTED,
  output logic               o_FAULT
);

  state_t             state_q, state_d;
  logic               step_mode_q, step_mode_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               in_xz, stall, expired, retire;

  assign in_xz  = (state_q == ST_X) || (state_q == ST_Z);
  assign stall  = in_xz && i_MEM_BUSY;
  assign retire = (state_q == ST_Z) && !i_MEM_BUSY;

  // Any cycle that is not a stall restarts the budget for the next phase.
  stall_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_stall_timer (
    .clk_i      (i_CLOCK),
    .rst_n_i    (i_RESET_N),
    .clear_i    (!stall),
    .count_en_i (stall),
    .expired_o  (expired)
  );

  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q     <= ST_HALTED;
      step_mode_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    count_d     = retire ? count_q + 1'b1 : count_q;
    unique case (state_q)
      ST_HALTED: begin
        if (i_RUN || i_STEP) begin
          state_d     = ST_X;
          step_mode_d = i_STEP;
        end
      end
      ST_X: begin
        if (!i_MEM_BUSY)  state_d = ST_Y;
        else if (expired) state_d = ST_FAULT;
      end
      ST_Y: state_d = ST_Z;
      ST_Z: begin
        if (!i_MEM_BUSY) begin
          // Halt wins over run; a stepped instruction always returns to HALTED.
          state_d     = (i_HALT || step_mode_q || !i_RUN) ? ST_HALTED : ST_X;
          step_mode_d = 1'b0;
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  always_comb begin
    o_CYCLEX      = (state_q == ST_X);
    o_CYCLEY      = (state_q == ST_Y);
    o_CYCLEZ      = (state_q == ST_Z);
    o_ADVANCE     = (in_xz && !i_MEM_BUSY) || (state_q == ST_Y);
    o_RETIRE      = retire;
    o_STATE       = state_q;
    o_INSTR_COUNT = count_q;
    o_HALTED      = (state_q == ST_HALTED);
    o_FAULT       = (state_q == ST_FAULT);
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a default instance plus one with
// WAIT_LIMIT=4, COUNT_W=4 sharing the same stimulus.
module tb_phase_sequencer;
  import crforth_pkg::*;

  logic clk = 1'b0;
  logic rst_n, run, step, busy, halt;

  logic        cx, cy, cz, adv, ret, halted, fault;
  logic [2:0]  st;
  logic [15:0] cnt;
  logic        cx_s, cy_s, cz_s, adv_s, ret_s, halted_s, fault_s;
  logic [2:0]  st_s;
  logic [3:0]  cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  phase_sequencer dut (
    .i_CLOCK(clk), .i_RESET_N(rst_n), .i_RUN(run), .i_STEP(step),
    .i_MEM_BUSY(busy), .i_HALT(halt),
    .o_CYCLEX(cx), .o_CYCLEY(cy), .o_CYCLEZ(cz), .o_ADVANCE(adv),
    .o_STATE(st), .o_RETIRE(ret), .o_INSTR_COUNT(cnt),
    .o_HALTED(halted), .o_FAULT(fault)
  );

  phase_sequencer #(.WAIT_LIMIT(4), .COUNT_W(4)) dut_s (
    .i_CLOCK(clk), .i_RESET_N(rst_n), .i_RUN(run), .i_STEP(step),
    .i_MEM_BUSY(busy), .i_HALT(halt),
    .o_CYCLEX(cx_s), .o_CYCLEY(cy_s), .o_CYCLEZ(cz_s), .o_ADVANCE(adv_s),
    .o_STATE(st_s), .o_RETIRE(ret_s), .o_INSTR_COUNT(cnt_s),
    .o_HALTED(halted_s), .o_FAULT(fault_s)
  );

  typedef struct {
    logic   run, step, busy, halt;
    state_t st;
    logic   adv, ret;
    int     cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, s, b, h, input state_t es, input logic ea, er, input int ec);
    vec_t v;
    v.run = r; v.step = s; v.busy = b; v.halt = h;
    v.st = es; v.adv = ea; v.ret = er; v.cnt = ec;
    vecs.push_back(v);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, s, b, h);
    @(negedge clk);
    run = r; step = s; busy = b; halt = h;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; step = 1'b0; busy = 1'b0; halt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic check_all(input string tag, input state_t es, input logic ea, er, input int ec);
    check($sformatf("%s state", tag), 32'(st), 32'(es));
    check($sformatf("%s strobes", tag), {cx, cy, cz}, {es == ST_X, es == ST_Y, es == ST_Z});
    check($sformatf("%s halted/fault", tag), {halted, fault}, {es == ST_HALTED, es == ST_FAULT});
    check($sformatf("%s advance", tag), adv, ea);
    check($sformatf("%s retire", tag), ret, er);
    check($sformatf("%s count", tag), cnt, ec[15:0]);
    check($sformatf("%s state_s", tag), 32'(st_s), 32'(es));
    check($sformatf("%s advance_s", tag), adv_s, ea);
    check($sformatf("%s retire_s", tag), ret_s, er);
    check($sformatf("%s count_s", tag), cnt_s, ec[3:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t step_seq [8];
    int nret;

    rst_n = 1'b0; run = 1'b0; step = 1'b0; busy = 1'b0; halt = 1'b0;

    // Free run: X,Y,Z x4 with retire every third cycle, then run drops at the last Z.
    add(1,0,0,0, ST_HALTED,0,0,0);
    for (int i = 0; i < 4; i++) begin
      add(1,0,0,0, ST_X,1,0,i);
      add(1,0,0,0, ST_Y,1,0,i);
      add((i == 3) ? 1'b0 : 1'b1,0,0,0, ST_Z,1,1,i);
    end
    add(0,0,0,0, ST_HALTED,0,0,4);
    // Single step, with a second step pulse during Y that must be ignored.
    add(0,1,0,0, ST_HALTED,0,0,4);
    add(0,0,0,0, ST_X,1,0,4);
    add(0,1,0,0, ST_Y,1,0,4);
    add(0,0,0,0, ST_Z,1,1,4);
    add(0,0,0,0, ST_HALTED,0,0,5);
    add(0,0,0,0, ST_HALTED,0,0,5);
    // Stalls: 3 busy cycles in X, busy ignored in Y, 2 busy cycles in Z, ignored in HALTED.
    add(1,0,0,0, ST_HALTED,0,0,5);
    add(1,0,1,0, ST_X,0,0,5);
    add(1,0,1,0, ST_X,0,0,5);
    add(1,0,1,0, ST_X,0,0,5);
    add(1,0,0,0, ST_X,1,0,5);
    add(1,0,1,0, ST_Y,1,0,5);
    add(1,0,1,0, ST_Z,0,0,5);
    add(1,0,1,0, ST_Z,0,0,5);
    add(0,0,0,0, ST_Z,1,1,5);
    add(0,0,1,0, ST_HALTED,0,0,6);
    // Halt ignored outside Z; halt beats run at the end of Z.
    add(1,0,0,0, ST_HALTED,0,0,6);
    add(1,0,0,1, ST_X,1,0,6);
    add(1,0,0,0, ST_Y,1,0,6);
    add(1,0,0,1, ST_Z,1,1,6);
    add(1,0,0,0, ST_HALTED,0,0,7);
    // Run dropped mid-instruction: the instruction still completes.
    add(0,0,0,0, ST_X,1,0,7);
    add(0,0,0,0, ST_Y,1,0,7);
    add(0,0,0,0, ST_Z,1,1,7);
    add(0,0,0,0, ST_HALTED,0,0,8);

    // Reset state, during and after reset.
    #1;
    check_all("reset_asserted", ST_HALTED, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset_released", ST_HALTED, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].run, vecs[i].step, vecs[i].busy, vecs[i].halt);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].adv, vecs[i].ret, vecs[i].cnt);
    end

    // Reset asserted during Y aborts the instruction at once without retiring.
    apply_reset();
    drive(1,0,0,0); check_all("rstY h", ST_HALTED, 0, 0, 0);
    drive(1,0,0,0); check_all("rstY x", ST_X, 1, 0, 0);
    drive(1,0,0,0); check_all("rstY y", ST_Y, 1, 0, 0);
    #1 rst_n = 1'b0; run = 1'b0;
    #1 check_all("rstY abort", ST_HALTED, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("rstY release", ST_HALTED, 0, 0, 0);
    drive(0,0,0,0); check_all("rstY idle", ST_HALTED, 0, 0, 0);

    // Step held high: one instruction per HALTED entry.
    step_seq = '{ST_HALTED, ST_X, ST_Y, ST_Z, ST_HALTED, ST_X, ST_Y, ST_Z};
    for (int i = 0; i < 8; i++) begin
      drive(0,1,0,0);
      check_all($sformatf("stephold%0d", i), step_seq[i], step_seq[i] != ST_HALTED,
                step_seq[i] == ST_Z, (i < 4) ? 0 : 1);
    end
    drive(0,0,0,0); check_all("stephold end", ST_HALTED, 0, 0, 2);
    // Run and step together: step mode still returns to HALTED with run high.
    drive(1,1,0,0); check_all("runstep h", ST_HALTED, 0, 0, 2);
    drive(1,0,0,0); check_all("runstep x", ST_X, 1, 0, 2);
    drive(1,0,0,0); check_all("runstep y", ST_Y, 1, 0, 2);
    drive(1,0,0,0); check_all("runstep z", ST_Z, 1, 1, 2);
    drive(0,0,0,0); check_all("runstep end", ST_HALTED, 0, 0, 3);

    // Timeout: 4 busy cycles then ready proceeds; 5 busy cycles fault the limit-4 instance.
    apply_reset();
    drive(1,0,1,0); check_all("to h", ST_HALTED, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1,0,1,0); check_all($sformatf("to busy4_%0d", i), ST_X, 0, 0, 0);
    end
    drive(1,0,0,0); check_all("to ready", ST_X, 1, 0, 0);
    drive(1,0,0,0); check_all("to y", ST_Y, 1, 0, 0);
    drive(1,0,0,0); check_all("to z", ST_Z, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1,0,1,0); check_all($sformatf("to busy5_%0d", i), ST_X, 0, 0, 1);
    end
    drive(1,0,1,0);
    check("fault state_s", 32'(st_s), 32'(ST_FAULT));
    check("fault flag_s", fault_s, 1'b1);
    check("fault strobes_s", {cx_s, cy_s, cz_s, halted_s, adv_s, ret_s}, 6'b0);
    check("fault default stays X", 32'(st), 32'(ST_X));
    check("fault default flag", fault, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1,0,0,0);
      check($sformatf("fault sticky%0d", i), {32'(st_s), fault_s}, {32'(ST_FAULT), 1'b1});
    end
    apply_reset();
    check("fault cleared_s", {32'(st_s), fault_s, halted_s}, {32'(ST_HALTED), 1'b0, 1'b1});

    // 17 instructions: default count reads 17, the 4-bit counter wraps to 1.
    nret = 0;
    drive(1,0,0,0); check_all("wrap h", ST_HALTED, 0, 0, 0);
    for (int i = 0; i < 51; i++) begin
      drive((i == 50) ? 1'b0 : 1'b1, 0, 0, 0);
      check($sformatf("wrap state%0d", i), 32'(st),
            32'((i % 3 == 0) ? ST_X : (i % 3 == 1) ? ST_Y : ST_Z));
      if (ret_s) nret++;
    end
    drive(0,0,0,0);
    check("wrap retires", nret, 17);
    check("wrap state", 32'(st), 32'(ST_HALTED));
    check("wrap count", cnt, 16'd17);
    check("wrap count_s", cnt_s, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
